// File: rtl/rcvr_uart_bridge.sv
// Receiver-to-host bridge: buffers accepted bytes in a small FIFO and sends them as 8N1 UART.
// Define UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module rcvr_uart_bridge #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rvalid,
  input  logic [7:0]                    rcvr_data,
  output logic                          rrdy,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PW       = AW + 1;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Handshake: a byte moves on a rising edge where rvalid && rrdy; rrdy is the
  // inverse of the registered full flag, so a pop never frees a slot in the same cycle.
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  state_t        r_state;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;

  logic          w_push;
  logic          w_pop;
  logic          w_baud_done;
  logic [PW-1:0] w_wr_next;
  logic [PW-1:0] w_rd_next;
  logic [PW-1:0] w_count_next;

  assign w_baud_done  = (r_baud_cnt == BAUD_LAST);
  assign w_push       = rvalid && !r_full;
  assign w_pop        = !r_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  assign w_wr_next    = r_wr_ptr + PW'(w_push);
  assign w_rd_next    = r_rd_ptr + PW'(w_pop);
  assign w_count_next = w_wr_next - w_rd_next;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= rcvr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_full   <= (w_count_next == PW'(FIFO_DEPTH));
      r_empty  <= (w_count_next == '0);
      if (w_pop) r_shift <= r_mem[r_rd_ptr[AW-1:0]];

      // txd lags the state by one cycle so every bit is a full BAUD_DIV wide.
      case (r_state)
        S_START:  r_txd <= 1'b0;
        S_DATA:   r_txd <= r_shift[r_bit_idx];
        S_PARITY: r_txd <= ^r_shift;
        default:  r_txd <= 1'b1;
      endcase

      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          if (!r_empty) r_state <= S_START;
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          // A waiting byte is popped in the last stop cycle, giving back-to-back frames.
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_state    <= r_empty ? S_IDLE : S_START;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        default: begin
          r_baud_cnt <= '0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign rrdy       = !r_full;
  assign txd        = r_txd;
  assign busy       = (r_state != S_IDLE) || !r_empty;
  assign fifo_count = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rcvr_uart_bridge.sv
// Bench for rcvr_uart_bridge: timeline model of FIFO + frame positions, a UART line decoder
// feeding a byte scoreboard, directed scenarios with literal expectations, and random traffic.
module tb_rcvr_uart_bridge;

  localparam int CF  = 1_000_000;
  localparam int BD  = 100_000;
  localparam int DEP = 4;
  localparam int D   = CF / BD;
`ifdef UART_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FL  = NB * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rvalid = 1'b0;
  logic [7:0] rcvr_data = 8'h00;
  logic       rrdy;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;
  logic [2:0] dbg_state;

  rcvr_uart_bridge #(.CLK_FREQ(CF), .BAUD(BD), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .rvalid(rvalid), .rcvr_data(rcvr_data),
    .rrdy(rrdy), .txd(txd), .busy(busy), .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // model: FIFO contents plus position inside the frame being sent (-1 = line idle)
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_pos = -1;
  logic [7:0] m_cur = 8'h00;
  logic       m_txd = 1'b1;
  int         n_acc = 0;

  int          mon_pos = -1;
  logic [10:0] mon_bits = '0;
  logic [10:0] last_bits = '0;
  logic [7:0]  last_byte = 8'h00;
  int          frames_rx = 0;
  int          prev_count = 0;
  logic        saw_full = 1'b0;
  logic        saw_4to3 = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic frame_bit(input int pos, input logic [7:0] b);
    int idx;
    idx = pos / D;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NB == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_pos   = -1;
    m_txd   = 1'b1;
    mon_pos = -1;
  endtask

  task automatic model_step();
    int  cnt_pre;
    int  pos_pre;
    logic push;
    logic pop;
    cnt_pre = m_q.size();
    pos_pre = m_pos;
    push = rvalid && (cnt_pre != DEP);
    m_txd = (pos_pre < 0) ? 1'b1 : frame_bit(pos_pre, m_cur);
    pop = (cnt_pre != 0) && (pos_pre < 0 || pos_pre == FL - 1);
    if (pos_pre >= 0) m_pos = (pos_pre == FL - 1) ? -1 : pos_pre + 1;
    if (pop) begin
      m_cur = m_q.pop_front();
      m_pos = 0;
    end
    if (push) begin
      m_q.push_back(rcvr_data);
      exp_q.push_back(rcvr_data);
      n_acc++;
    end
  endtask

  task automatic mon_step();
    logic [7:0] b;
    if (mon_pos < 0) begin
      if (txd == 1'b0) mon_pos = 0;
      else return;
    end
    if (mon_pos % D == D / 2) mon_bits[mon_pos / D] = txd;
    if (mon_pos == (NB - 1) * D + D / 2) begin
      b = mon_bits[8:1];
      chk("uart_start_bit", mon_bits[0], 0);
      chk("uart_stop_bit", mon_bits[NB-1], 1);
`ifdef UART_PARITY_EN
      chk("uart_parity_bit", mon_bits[9], ^b);
`endif
      if (exp_q.size() == 0) chk("uart_unexpected_frame", 1, 0);
      else chk("uart_byte", b, exp_q.pop_front());
      frames_rx++;
      last_bits = mon_bits;
      last_byte = b;
      mon_pos = -1;
    end else begin
      mon_pos++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
  end

  // per-cycle compare, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    chk("txd", txd, m_txd);
    chk("rrdy", rrdy, int'(m_q.size() != DEP));
    chk("busy", busy, int'(m_pos >= 0 || m_q.size() != 0));
    chk("fifo_count", fifo_count, m_q.size());
    if (fifo_count == 3'd4) saw_full = 1'b1;
    if (prev_count == 4 && fifo_count == 3'd3 && rrdy) saw_4to3 = 1'b1;
    prev_count = fifo_count;
    if (rst) mon_step();
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks (called right after a falling edge)
  task automatic push_byte(input logic [7:0] b);
    int n;
    rvalid = 1'b1;
    rcvr_data = b;
    n = 0;
    while (!rrdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("push_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || mon_pos >= 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // count edges from the last push edge until txd falls, then until busy drops
  task automatic measure(input int k0, output int k_fall, output int k_idle);
    int k;
    k = k0;
    while (txd && k < 500) begin
      @(posedge clk); k++; @(negedge clk);
    end
    k_fall = k;
    while (busy && k < 500) begin
      @(posedge clk); k++; @(negedge clk);
    end
    k_idle = k;
  endtask

  logic [7:0] six [6] = '{8'h10, 8'h22, 8'h34, 8'h46, 8'h58, 8'h6A};

  initial begin
    int kf, ki, f0, a0;
    logic pending;
    logic rrdy_last;

    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_rrdy", rrdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fifo_count", fifo_count, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single 0x41 frame
    push_byte(8'h41);
    measure(0, kf, ki);
    chk("s1_txd_fall_latency", kf, 2);
`ifdef UART_PARITY_EN
    chk("s1_busy_drop", ki, 111);
`else
    chk("s1_busy_drop", ki, 101);
`endif
    wait_idle();
    chk("s1_byte", last_byte, 8'h41);
`ifndef UART_PARITY_EN
    chk("s1_bits", last_bits[9:0], 10'b1010000010);
`endif

    // '+' then '!' back-to-back
    f0 = frames_rx;
    push_byte(8'h2B);
    push_byte(8'h21);
    measure(1, kf, ki);
    chk("s2_txd_fall_latency", kf, 2);
`ifdef UART_PARITY_EN
    chk("s2_total_len", ki, 221);
`else
    chk("s2_total_len", ki, 201);
`endif
    wait_idle();
    chk("s2_frames", frames_rx - f0, 2);
    chk("s2_last_byte", last_byte, 8'h21);

    // rvalid held across six bytes, FIFO fills and drains
    f0 = frames_rx;
    saw_full = 1'b0;
    saw_4to3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int n;
      rvalid = 1'b1;
      rcvr_data = six[i];
      n = 0;
      while (!rrdy && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) chk("s3_push_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
    end
    rvalid = 1'b0;
    wait_idle();
    chk("s3_reached_full", saw_full, 1);
    chk("s3_full_pop_4to3", saw_4to3, 1);
    chk("s3_frames", frames_rx - f0, 6);
    chk("s3_last_byte", last_byte, 8'h6A);

    // reset in the middle of the data bits of 0xA5
    push_byte(8'hA5);
    push_byte(8'h3C);
    repeat (30) @(negedge clk);
    chk("s4_pre_reset_count", fifo_count, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("s4_reset_txd", txd, 1);
    chk("s4_reset_fifo_count", fifo_count, 0);
    chk("s4_reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    f0 = frames_rx;
    push_byte(8'h5A);
    measure(0, kf, ki);
    chk("s4_fresh_start", kf, 2);
    wait_idle();
    chk("s4_frames", frames_rx - f0, 1);
    chk("s4_byte", last_byte, 8'h5A);

`ifdef UART_PARITY_EN
    push_byte(8'h07);
    measure(0, kf, ki);
    chk("par_busy_drop", ki, 111);
    wait_idle();
    chk("par_bits", last_bits, 11'b11000001110);
`endif

    // random traffic; an offered byte is held until taken
    f0 = frames_rx;
    a0 = n_acc;
    pending = 1'b0;
    rrdy_last = rrdy;
    for (int c = 0; c < 3000; c++) begin
      pending = rvalid && !rrdy_last;
      if (!pending) begin
        rvalid = ($urandom_range(0, 99) < 4);
        rcvr_data = 8'($urandom_range(0, 255));
      end
      rrdy_last = rrdy;
      @(posedge clk);
      @(negedge clk);
    end
    rvalid = 1'b0;
    wait_idle();
    chk("rand_frames", frames_rx - f0, n_acc - a0);
    chk("rand_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
